// File: rtl/cache_def_pkg.sv
// cache_def_pkg: shared geometry, array/bus structs, FSM state codes and word-merge helper for dm_cache_ctrl
package cache_def_pkg;
  localparam int TAGMSB  = 31;
  localparam int TAGLSB  = 14;
  localparam int INDEX_W = 10;
  localparam int LINE_W  = 128;
  localparam int TAG_W   = TAGMSB - TAGLSB + 1;
  typedef logic [LINE_W-1:0] cache_data_type;
  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic               we;
  } cache_req_type;
  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } cache_tag_type;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;
  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;
  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;
  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;
  typedef logic [1:0] state_t;
  localparam state_t IDLE        = 2'd0;
  localparam state_t COMPARE_TAG = 2'd1;
  localparam state_t WRITE_BACK  = 2'd2;
  localparam state_t ALLOCATE    = 2'd3;
  function automatic cache_data_type merge_word(input cache_data_type line, input logic [1:0] w,
                                                input logic [31:0] d);
    cache_data_type r;
    r = line;
    r[{w, 5'd0} +: 32] = d;
    return r;
  endfunction
endpackage

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: write-back/write-allocate direct-mapped cache controller FSM (1024 x 128-bit lines)
//  cpu_*  : word request in (held until cpu_res_ready), one-cycle completion pulse + read word out
//  data_* : data array index/we, write line out, combinational read line in
//  tag_*  : tag array index/we, {valid,dirty,tag} out, combinational entry in
//  mem_*  : line fetch / write-back request out, one-cycle completion pulse + fetched line in
//  Define CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module dm_cache_ctrl
  import cache_def_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cpu_req_valid,
  input  logic           cpu_req_rw,
  input  logic [31:0]    cpu_req_addr,
  input  logic [31:0]    cpu_req_data,
  output logic           cpu_req_ready,
  output logic           cpu_res_ready,
  output logic [31:0]    cpu_res_data,
  output cache_req_type  data_req,
  output cache_data_type data_write,
  input  cache_data_type data_read,
  output cache_req_type  tag_req,
  output cache_tag_type  tag_write,
  input  cache_tag_type  tag_read,
  output logic           mem_req_valid,
  output logic           mem_req_rw,
  output logic [31:0]    mem_req_addr,
  output cache_data_type mem_req_data,
  input  logic           mem_resp_ready,
  input  cache_data_type mem_resp_data
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]    hit_cnt,
  output logic [31:0]    miss_cnt
`endif
);
  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, res_data_q, res_data_d;
  logic             rw_q, rw_d, res_ready_q, res_ready_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  cache_data_type   wb_data_q, wb_data_d;
  logic             data_we, tag_we, hit;
  logic [TAG_W-1:0] req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [1:0]       req_word;
  assign req_tag  = addr_q[TAGMSB:TAGLSB];
  assign req_idx  = addr_q[TAGLSB-1 -: INDEX_W];
  assign req_word = addr_q[3:2];
  assign hit      = tag_read.valid && tag_read.tag == req_tag;
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rw_d        = rw_q;
    res_ready_d = 1'b0;
    res_data_d  = res_data_q;
    wb_tag_d    = wb_tag_q;
    wb_data_d   = wb_data_q;
    data_we     = 1'b0;
    tag_we      = 1'b0;
    data_write  = mem_resp_data;
    tag_write   = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
    case (state_q)
      // the CPU still holds valid during the completion pulse; that cycle is not a new request
      IDLE: if (cpu_req_valid && !res_ready_q) begin
        addr_d  = cpu_req_addr;
        wdata_d = cpu_req_data;
        rw_d    = cpu_req_rw;
        state_d = COMPARE_TAG;
      end
      COMPARE_TAG: if (hit) begin
        res_ready_d = 1'b1;
        res_data_d  = data_read[{req_word, 5'd0} +: 32];
        state_d     = IDLE;
        if (rw_q) begin
          data_we    = 1'b1;
          data_write = merge_word(data_read, req_word, wdata_q);
          tag_we     = 1'b1;
          tag_write  = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
        end
      end else if (tag_read.valid && tag_read.dirty) begin
        wb_tag_d  = tag_read.tag;
        wb_data_d = data_read;
        state_d   = WRITE_BACK;
      end else begin
        state_d = ALLOCATE;
      end
      WRITE_BACK: state_d = mem_resp_ready ? ALLOCATE : WRITE_BACK;
      ALLOCATE: if (mem_resp_ready) begin
        data_we = 1'b1;
        tag_we  = 1'b1;
        state_d = COMPARE_TAG;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rw_q        <= 1'b0;
      res_ready_q <= 1'b0;
      res_data_q  <= '0;
      wb_tag_q    <= '0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rw_q        <= rw_d;
      res_ready_q <= res_ready_d;
      res_data_q  <= res_data_d;
      wb_tag_q    <= wb_tag_d;
      wb_data_q   <= wb_data_d;
    end
  end
  // array writes are suppressed while reset is held so an aborted refill leaves the arrays untouched
  assign data_req      = '{index: req_idx, we: data_we && rst_n};
  assign tag_req       = '{index: req_idx, we: tag_we && rst_n};
  assign cpu_req_ready = state_q == IDLE;
  assign cpu_res_ready = res_ready_q;
  assign cpu_res_data  = res_data_q;
  assign mem_req_valid = state_q == WRITE_BACK || state_q == ALLOCATE;
  assign mem_req_rw    = state_q == WRITE_BACK;
  assign mem_req_addr  = mem_req_rw ? {wb_tag_q, req_idx, 4'h0} : {req_tag, req_idx, 4'h0};
  assign mem_req_data  = wb_data_q;
`ifdef CACHE_STATS_EN
  // refill marks the re-compare after ALLOCATE so each request is counted once
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        refill_q, refill_d;
  always_comb begin
    refill_d   = state_q == ALLOCATE ? mem_resp_ready : state_q == COMPARE_TAG ? 1'b0 : refill_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == COMPARE_TAG && !refill_q) begin
      hit_cnt_d  = hit && hit_cnt_q != '1 ? hit_cnt_q + 32'd1 : hit_cnt_q;
      miss_cnt_d = !hit && miss_cnt_q != '1 ? miss_cnt_q + 32'd1 : miss_cnt_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      refill_q   <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      refill_q   <= refill_d;
    end
  end
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: scoreboard bench with golden-memory reference model, array and memory models
module tb_dm_cache_ctrl;
  import cache_def_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic           cpu_req_valid = 1'b0, cpu_req_rw = 1'b0;
  logic [31:0]    cpu_req_addr = '0, cpu_req_data = '0;
  logic           cpu_req_ready, cpu_res_ready;
  logic [31:0]    cpu_res_data;
  cache_req_type  data_req, tag_req;
  cache_data_type data_write, data_read;
  cache_tag_type  tag_write, tag_read;
  logic           mem_req_valid, mem_req_rw;
  logic [31:0]    mem_req_addr;
  cache_data_type mem_req_data;
  logic           mem_resp_ready = 1'b0;
  cache_data_type mem_resp_data = '0;
`ifdef CACHE_STATS_EN
  logic [31:0]    hit_cnt, miss_cnt;
`endif
  dm_cache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw), .cpu_req_addr(cpu_req_addr),
    .cpu_req_data(cpu_req_data), .cpu_req_ready(cpu_req_ready), .cpu_res_ready(cpu_res_ready),
    .cpu_res_data(cpu_res_data), .data_req(data_req), .data_write(data_write), .data_read(data_read),
    .tag_req(tag_req), .tag_write(tag_write), .tag_read(tag_read),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );
  bit [127:0] data_arr [1024];
  bit [19:0]  tag_arr [1024];
  assign data_read = data_arr[data_req.index];
  assign tag_read  = tag_arr[tag_req.index];
  always @(posedge clk) begin
    if (data_req.we) data_arr[data_req.index] <= data_write;
    if (tag_req.we) tag_arr[tag_req.index] <= tag_write;
  end
  typedef struct {
    bit             rw;
    logic [31:0]    addr;
    cache_data_type data;
  } mexp_t;
  mexp_t          exp_mem[$];
  logic [31:0]    exp_res[$];
  cache_data_type gold [logic [27:0]];
  cache_data_type dmem [logic [27:0]];
  bit             ref_v [1024];
  bit             ref_d [1024];
  logic [17:0]    ref_t [1024];
  int             m_hit = 0, m_miss = 0;
  int             checks = 0, errors = 0;
  int             mem_lat = 3;
  bit             hold_mem = 1'b0;
  function automatic cache_data_type dflt(input logic [27:0] la);
    return {{la, 4'hC} ^ 32'hA5A5_0000, {la, 4'h8} ^ 32'hA5A5_0000,
            {la, 4'h4} ^ 32'hA5A5_0000, {la, 4'h0} ^ 32'hA5A5_0000};
  endfunction
  function automatic cache_data_type gold_line(input logic [27:0] la);
    return gold.exists(la) ? gold[la] : dflt(la);
  endfunction
  function automatic cache_data_type dmem_line(input logic [27:0] la);
    return dmem.exists(la) ? dmem[la] : dflt(la);
  endfunction
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask
  // reference: memory is the golden word store; the cache view only decides hit/miss and traffic
  task automatic model(input logic [31:0] a, input bit rw, input logic [31:0] d, output bit hit);
    logic [9:0]     i;
    logic [17:0]    t;
    cache_data_type ln;
    i = a[13:4];
    t = a[31:14];
    hit = ref_v[i] && ref_t[i] == t;
    if (hit) m_hit++;
    else begin
      m_miss++;
      if (ref_v[i] && ref_d[i])
        exp_mem.push_back('{1'b1, {ref_t[i], i, 4'h0}, gold_line({ref_t[i], i})});
      exp_mem.push_back('{1'b0, {t, i, 4'h0}, '0});
      ref_v[i] = 1'b1;
      ref_t[i] = t;
      ref_d[i] = 1'b0;
    end
    ln = gold_line(a[31:4]);
    exp_res.push_back(ln[int'(a[3:2]) * 32 +: 32]);
    if (rw) begin
      ln[int'(a[3:2]) * 32 +: 32] = d;
      gold[a[31:4]] = ln;
      ref_d[i] = 1'b1;
    end
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!(cpu_req_ready && !cpu_res_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("wait_ready_timeout");
  endtask
  task automatic do_req(input logic [31:0] a, input bit rw, input logic [31:0] d);
    bit hit;
    int n = 0;
    model(a, rw, d, hit);
    wait_ready();
    cpu_req_addr  = a;
    cpu_req_rw    = rw;
    cpu_req_data  = d;
    cpu_req_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_res_ready && n < 500);
    cpu_req_valid = 1'b0;
    if (!cpu_res_ready) fail_now("response_timeout");
    else if (hit) check("hit_latency", n, 2);
  endtask
  always @(negedge clk) begin
    if (rst_n && cpu_res_ready) begin
      if (exp_res.size() == 0) fail_now("unexpected_cpu_response");
      else check("cpu_res_data", cpu_res_data, exp_res.pop_front());
    end
  end
  initial begin
    mexp_t          e;
    int             lat;
    bit             rw;
    logic [31:0]    ra;
    cache_data_type rd;
    forever begin
      @(negedge clk);
      while (mem_req_valid) begin
        if (exp_mem.size() == 0) fail_now("unexpected_mem_request");
        else begin
          e = exp_mem.pop_front();
          check("mem_req_rw", mem_req_rw, e.rw);
          check("mem_req_addr", mem_req_addr, e.addr);
          if (e.rw) check("mem_wb_data", mem_req_data, e.data);
        end
        rw  = mem_req_rw;
        ra  = mem_req_addr;
        rd  = mem_req_data;
        lat = mem_lat > 0 ? mem_lat : int'($urandom_range(1, 4));
        repeat (lat) @(negedge clk);
        while (hold_mem) @(negedge clk);
        mem_resp_data = rw ? '0 : dmem_line(ra[31:4]);
        if (rw) dmem[ra[31:4]] = rd;
        mem_resp_ready = 1'b1;
        @(negedge clk);
        mem_resp_ready = 1'b0;
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] a;
    int          n;
    gold[28'h1] = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    dmem[28'h1] = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    repeat (3) @(negedge clk);
    check("rst_req_ready", cpu_req_ready, 1);
    check("rst_res_ready", cpu_res_ready, 0);
    check("rst_res_data", cpu_res_data, 0);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_data_we", data_req.we, 0);
    check("rst_tag_we", tag_req.we, 0);
`ifdef CACHE_STATS_EN
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    do_req(32'h0000_0010, 1'b0, 32'h0);
    check("t1_tag", tag_arr[1], 20'h80000);
    do_req(32'h0000_0014, 1'b0, 32'h0);
    do_req(32'h0000_0018, 1'b1, 32'h1234_5678);
    check("t3_tag_dirty", tag_arr[1], 20'hC0000);
    check("t3_word2", data_arr[1][95:64], 32'h1234_5678);
    do_req(32'h0000_4010, 1'b0, 32'h0);
    check("t4_tag", tag_arr[1], 20'h80001);
    check("t4_wb_in_mem", dmem_line(28'h1), 128'hDDDD_DDDD_1234_5678_BBBB_BBBB_AAAA_AAAA);
`ifdef CACHE_STATS_EN
    check("t6_hit_cnt", hit_cnt, 2);
    check("t6_miss_cnt", miss_cnt, 2);
`endif
    exp_mem.push_back('{1'b0, 32'h0000_0050, '0});
    hold_mem = 1'b1;
    wait_ready();
    cpu_req_addr  = 32'h0000_0050;
    cpu_req_rw    = 1'b0;
    cpu_req_valid = 1'b1;
    n = 0;
    while (!(mem_req_valid && !mem_req_rw) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_alloc", mem_req_valid, 1);
    rst_n = 1'b0;
    cpu_req_valid = 1'b0;
    @(negedge clk);
    check("t5_idle_after_rst", cpu_req_ready, 1);
    check("t5_mem_valid_drop", mem_req_valid, 0);
    rst_n = 1'b1;
    hold_mem = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_no_tag_write", tag_arr[5], 0);
    check("t5_no_data_write", data_arr[5], 0);
    m_hit = 0;
    m_miss = 0;
    do_req(32'h0000_0050, 1'b0, 32'h0);
    check("t5_tag_after", tag_arr[5], 20'h80000);
    mem_lat = 0;
    for (int k = 0; k < 300; k++) begin
      a = {18'($urandom_range(0, 3)), 10'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
      do_req(a, 1'($urandom_range(0, 1)), $urandom);
    end
    repeat (10) @(negedge clk);
`ifdef CACHE_STATS_EN
    check("rand_hit_cnt", hit_cnt, m_hit);
    check("rand_miss_cnt", miss_cnt, m_miss);
`endif
    check("exp_res_drained", exp_res.size(), 0);
    check("exp_mem_drained", exp_mem.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
